// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_gen
//  Purpose  : Single-clock LED animation engine (off / blink / chase / bounce)
//             advanced by a clock-enable prescaler tick.
//  Revision : 1.0
// ============================================================================
module led_pattern_gen #(
  parameter int N_LEDS   = 10,
  parameter int TICK_DIV = 131072,
  parameter int CNT_W    = $clog2(TICK_DIV),
  parameter int POS_W    = ($clog2(N_LEDS) > 0) ? $clog2(N_LEDS) : 1
) (
  input  logic              ADC_CLK_10,
  input  logic              RESET_N,
  input  logic [1:0]        sel,
  input  logic              run,
  output logic [N_LEDS-1:0] LEDR,
  output logic              step_tick,
  output logic              dir
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

  mode_t             sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              blink_q, blink_d;
  logic              step_tick_q, step_tick_d;
  logic [N_LEDS-1:0] ledr_q, ledr_d;

  always_comb begin
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    blink_d     = blink_q;
    step_tick_d = 1'b0;
    ledr_d      = '0;

    // Output decode always reflects the state before this edge's update.
    case (sel_q)
      MODE_OFF:    ledr_d = '0;
      MODE_BLINK:  ledr_d = {N_LEDS{blink_q}};
      MODE_CHASE,
      MODE_BOUNCE: ledr_d = LED_ONE << pos_q;
      default:     ledr_d = '0;
    endcase

    if (mode_t'(sel) != sel_q) begin
      // Restart cleanly; any tick falling on this edge is dropped.
      sel_d   = mode_t'(sel);
      cnt_d   = '0;
      pos_d   = '0;
      dir_d   = 1'b0;
      blink_d = 1'b1;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        step_tick_d = 1'b1;
        case (sel_q)
          MODE_BLINK: blink_d = ~blink_q;
          MODE_CHASE: pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
          MODE_BOUNCE: begin
            // A single LED has nowhere to bounce, so position stays put.
            if (N_LEDS > 1) begin
              if (!dir_q) begin
                if (pos_q == LAST_POS) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = pos_q + 1'b1;
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_q       <= MODE_OFF;
      cnt_q       <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      blink_q     <= 1'b1;
      step_tick_q <= 1'b0;
      ledr_q      <= '0;
    end else begin
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      blink_q     <= blink_d;
      step_tick_q <= step_tick_d;
      ledr_q      <= ledr_d;
    end
  end

  assign LEDR      = ledr_q;
  assign step_tick = step_tick_q;
  assign dir       = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_gen
//  Purpose  : Self-checking bench for led_pattern_gen (N_LEDS=5, TICK_DIV=4).
//  Revision : 1.0
// ============================================================================
module tb_led_pattern_gen;

  localparam int N   = 5;
  localparam int TD  = 4;
  localparam int PER = 2 * N - 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   sel;
  logic         run;
  wire  [N-1:0] ledr;
  wire          step_tick;
  wire          dir;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, prescaler count and number of steps taken since
  // the mode was entered; patterns are derived arithmetically from the step.
  int           m_sel, m_cnt, m_step;
  logic [N-1:0] exp_ledr;
  logic         exp_tick, exp_dir;

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LEDS(N), .TICK_DIV(TD)) dut (
    .ADC_CLK_10 (clk),
    .RESET_N    (rst_n),
    .sel        (sel),
    .run        (run),
    .LEDR       (ledr),
    .step_tick  (step_tick),
    .dir        (dir)
  );

  function automatic logic [N-1:0] pattern(int ms, int st);
    logic [N-1:0] one;
    int p;
    one = 1;
    case (ms)
      0: return '0;
      1: return (st % 2 == 0) ? '1 : '0;
      2: return one << (st % N);
      default: begin
        p = st % PER;
        return one << ((p < N) ? p : PER - p);
      end
    endcase
  endfunction

  // Heading toward LSB from the step that leaves the top LED until the step
  // that leaves the bottom LED again.
  function automatic logic dir_of(int ms, int st);
    return (ms == 3) && (st >= N) && (((st - N) % PER) < (N - 1));
  endfunction

  task automatic model_reset();
    m_sel    = 0;
    m_cnt    = 0;
    m_step   = 0;
    exp_ledr = '0;
    exp_tick = 1'b0;
    exp_dir  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    exp_ledr = pattern(m_sel, m_step);
    if (int'(sel) != m_sel) begin
      m_sel    = int'(sel);
      m_cnt    = 0;
      m_step   = 0;
      exp_tick = 1'b0;
    end else if (!run) begin
      exp_tick = 1'b0;
    end else if (m_cnt == TD - 1) begin
      m_cnt    = 0;
      m_step   = m_step + 1;
      exp_tick = 1'b1;
    end else begin
      m_cnt    = m_cnt + 1;
      exp_tick = 1'b0;
    end
    exp_dir = dir_of(m_sel, m_step);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ledr !== '0 || step_tick !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial ledr=%b tick=%b dir=%b required 00000/0/0", ledr, step_tick, dir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 2'd2;
    run   = 1'b1;
    repeat (9) begin
      cycle();
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL reset_prerun ledr=%b/%b tick=%b/%b dir=%b/%b", ledr, exp_ledr, step_tick, exp_tick, dir, exp_dir);
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ledr !== '0 || step_tick !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_async ledr=%b tick=%b dir=%b required 00000/0/0", ledr, step_tick, dir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      cycle();
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL reset_release ledr=%b/%b tick=%b/%b dir=%b/%b", ledr, exp_ledr, step_tick, exp_tick, dir, exp_dir);
      end
    end
  endtask

  task automatic test_chase();
    int ticks = 0;
    sel = 2'd2;
    run = 1'b1;
    repeat (24) begin
      cycle();
      if (step_tick === 1'b1) ticks++;
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL chase ledr=%b/%b tick=%b/%b dir=%b/%b", ledr, exp_ledr, step_tick, exp_tick, dir, exp_dir);
      end
    end
    checks++;
    if (ticks != 6) begin
      errors++;
      $display("FAIL chase_tick_rate ticks=%0d required 6", ticks);
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq[$];
    logic [N-1:0] want[10];
    want = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
             5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00010};
    sel = 2'd3;
    run = 1'b1;
    cycle();
    cycle();
    seq.push_back(ledr);
    repeat (44) begin
      cycle();
      if (ledr !== seq[$]) seq.push_back(ledr);
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL bounce ledr=%b/%b tick=%b/%b dir=%b/%b", ledr, exp_ledr, step_tick, exp_tick, dir, exp_dir);
      end
    end
    checks++;
    if (seq.size() < 10) begin
      errors++;
      $display("FAIL bounce_seq_len got=%0d required>=10", seq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (seq[i] !== want[i]) begin
          errors++;
          $display("FAIL bounce_seq[%0d] got=%b required=%b", i, seq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_pause();
    int guard = 0;
    sel = 2'd2;
    run = 1'b1;
    cycle();
    while (!(m_sel == 2 && m_step == 2 && m_cnt == 2) && guard < 100) begin
      cycle();
      guard++;
    end
    checks++;
    if (guard >= 100 || ledr !== 5'b00100) begin
      errors++;
      $display("FAIL pause_setup guard=%0d ledr=%b required 00100", guard, ledr);
    end
    run = 1'b0;
    repeat (10) begin
      cycle();
      checks++;
      if (ledr !== 5'b00100 || step_tick !== 1'b0 || ledr !== exp_ledr) begin
        errors++;
        $display("FAIL pause_hold ledr=%b tick=%b required 00100/0", ledr, step_tick);
      end
    end
    run = 1'b1;
    cycle();
    checks++;
    if (step_tick !== 1'b0 || ledr !== 5'b00100) begin
      errors++;
      $display("FAIL pause_resume1 ledr=%b tick=%b required 00100/0", ledr, step_tick);
    end
    cycle();
    checks++;
    if (step_tick !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume_tick tick=%b required 1", step_tick);
    end
    repeat (3) begin
      cycle();
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL pause_after ledr=%b/%b tick=%b/%b", ledr, exp_ledr, step_tick, exp_tick);
      end
    end
  endtask

  task automatic test_mode_change_on_tick();
    int guard = 0;
    int k;
    sel = 2'd3;
    run = 1'b1;
    cycle();
    cycle();
    while (m_cnt != TD - 1 && guard < 20) begin
      cycle();
      guard++;
    end
    sel = 2'd2;
    cycle();
    checks++;
    if (guard >= 20 || step_tick !== 1'b0 || step_tick !== exp_tick) begin
      errors++;
      $display("FAIL modechg_drop guard=%0d tick=%b required 0", guard, step_tick);
    end
    cycle();
    checks++;
    if (ledr !== 5'b00001 || ledr !== exp_ledr) begin
      errors++;
      $display("FAIL modechg_ledr ledr=%b required 00001", ledr);
    end
    k = 2;
    while (step_tick !== 1'b1 && k < 10) begin
      cycle();
      k++;
    end
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL modechg_next_step edges=%0d required 5", k);
    end
  endtask

  task automatic test_blink_off();
    int ticks = 0;
    sel = 2'd1;
    run = 1'b1;
    cycle();
    cycle();
    checks++;
    if (ledr !== 5'b11111) begin
      errors++;
      $display("FAIL blink_start ledr=%b required 11111", ledr);
    end
    repeat (20) begin
      cycle();
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL blink ledr=%b/%b tick=%b/%b", ledr, exp_ledr, step_tick, exp_tick);
      end
    end
    sel = 2'd0;
    cycle();
    cycle();
    repeat (16) begin
      cycle();
      if (step_tick === 1'b1) ticks++;
      checks++;
      if (ledr !== 5'b00000 || step_tick !== exp_tick) begin
        errors++;
        $display("FAIL off ledr=%b tick=%b/%b required 00000", ledr, step_tick, exp_tick);
      end
    end
    checks++;
    if (ticks != 4) begin
      errors++;
      $display("FAIL off_ticks ticks=%0d required 4", ticks);
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
      run = ($urandom_range(0, 9) != 0);
      cycle();
      checks++;
      if (ledr !== exp_ledr || step_tick !== exp_tick || dir !== exp_dir) begin
        errors++;
        $display("FAIL random sel=%0d run=%b ledr=%b/%b tick=%b/%b dir=%b/%b",
                 sel, run, ledr, exp_ledr, step_tick, exp_tick, dir, exp_dir);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    sel   = 2'd0;
    run   = 1'b0;
    model_reset();
    test_reset();
    test_chase();
    test_bounce();
    test_pause();
    test_mode_change_on_tick();
    test_blink_off();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
